bip_program_loader: RTL
=======================

Name: bip_program_loader

Overview:
- Byte-stream program loader for the BIP system. It is the write side of the program memory, which the cpu only reads.
- Takes bytes from a UART receiver (valid/data strobe) and assembles them into 16-bit instruction words.
- Drives a write port into program memory.
- Holds the cpu in reset until a complete, valid image has been written, then releases it.

Parameters:
- NBITS_O, 11, program memory address width.
- NBITS_D, 16, instruction word width; fixed at 16 (two bytes per word).
- CELDAS, 10, program memory depth in words; maximum accepted image length.

Ports:
- i_clk  input  1  system clock.
- i_reset  input  1  synchronous, active-high reset.
- i_RxData  input  8  received byte.
- i_RxValid  input  1  one-cycle strobe; i_RxData is valid this cycle.
- o_PmWrAddr  output  NBITS_O  program memory write address.
- o_PmWrData  output  NBITS_D  program memory write data.
- o_PmWr  output  1  program memory write enable, one cycle per word.
- o_CpuReset  output  1  reset to cpu; high while loading or in error.
- o_Done  output  1  image loaded, cpu running.
- o_Error  output  1  image rejected.

Behaviour:
- All outputs are registered. On reset: o_CpuReset=1; o_PmWr=0; o_PmWrAddr=0; o_PmWrData=0; o_Done=0; o_Error=0; state=IDLE; word counter=0; checksum=0.
- Image format:
  - byte 0 = N, the word count.
  - then N words, each sent low byte first, then high byte.
  - then, only with CHECKSUM_EN, one checksum byte.
- Cycles with i_RxValid=0 never change state.
- States:
  - IDLE: on i_RxValid, latch N. If N==0 or N>CELDAS go to ERR, else go to LOW.
  - LOW: on i_RxValid, latch the low byte and go to HIGH.
  - HIGH: on i_RxValid, {i_RxData, low} forms the word.
    - The next cycle: o_PmWr=1, o_PmWrData=word, o_PmWrAddr=current index.
    - The index starts at 0 and increments after each write.
    - If the word just written was the N-th: go to CHK when CHECKSUM_EN is defined, else go to RUN. Otherwise go back to LOW.
  - CHK: on i_RxValid, compare i_RxData with the running checksum. Match goes to RUN; mismatch goes to ERR.
  - RUN: o_CpuReset=0 and o_Done=1 from the cycle after entry. Further bytes are ignored and no writes occur. Exit only by i_reset.
  - ERR: o_Error=1, o_CpuReset stays 1, bytes are ignored. Exit only by i_reset.
- o_PmWr is never high for two consecutive cycles.
- Exactly N write pulses occur per accepted image, at addresses 0..N-1 in order.
- o_PmWrAddr and o_PmWrData hold their last value when o_PmWr=0.
- Reset mid-load: all state returns to IDLE and o_CpuReset returns to 1. Words already written stay in memory and are not cleared; the next image overwrites them.
- i_RxValid asserted in the same cycle as i_reset is ignored.
- Back-to-back i_RxValid (every cycle) is supported. A strobe arriving in the write cycle is accepted normally.

Optional Feature:
- Macro: BIP_LOADER_CHECKSUM_EN.
- Defined:
  - An 8-bit running XOR of all word bytes is kept. N is excluded.
  - The checksum is cleared in IDLE.
  - After the last word the FSM enters CHK and needs one more byte. RUN is entered only on a match; a mismatch enters ERR.
  - Words already written before a mismatch remain in memory, but the cpu is not released.
- Undefined: no CHK state and no checksum register. RUN is entered on the cycle after the N-th write.

Test Plan:
- Load, checksum off. Bytes 03, 01,A0, 02,B0, 03,C0 -> writes A001@0, B002@1, C003@2. o_CpuReset falls and o_Done=1 only after the third write.
- Bad count. N=00 -> o_Error=1, no writes. After reset, N=0B (CELDAS=10) -> o_Error=1, no writes.
- Checksum, BIP_LOADER_CHECKSUM_EN defined. Bytes 01, 34,12 then checksum 26 -> write 1234@0, then RUN. Same stream with checksum 27 -> ERR, o_CpuReset stays 1.
- Reset mid-load. Send 02, 11,22, 33, then pulse i_reset, then send 01, 55,66 -> writes 2211@0, then 6655@0. RUN is reached and o_PmWrAddr never reaches 1 in the second image.
- Back-to-back and post-RUN. Stream 02, AA,BB, CC,DD with i_RxValid held high every cycle -> writes BBAA@0, DDCC@1. Bytes sent after RUN produce no o_PmWr and no state change.

Source files
------------

// File: rtl/bip_program_loader.sv
// Program loader: assembles received bytes into 16-bit words and writes program memory,
// holding the cpu in reset until the image is complete. Optional checksum: BIP_LOADER_CHECKSUM_EN.
module bip_program_loader #(
   parameter int NBITS_O = 11,
   parameter int NBITS_D = 16,
   parameter int CELDAS  = 10
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_RxData,
   input  logic               i_RxValid,
   output logic [NBITS_O-1:0] o_PmWrAddr,
   output logic [NBITS_D-1:0] o_PmWrData,
   output logic               o_PmWr,
   output logic               o_CpuReset,
   output logic               o_Done,
   output logic               o_Error,
   output logic [2:0]         o_State
);

   // Handshake: a byte is taken on every cycle with i_RxValid=1 (no back-pressure);
   // o_PmWr is a one-cycle write strobe with address/data valid in the same cycle.
   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOW  = 3'd1,
      HIGH = 3'd2,
`ifdef BIP_LOADER_CHECKSUM_EN
      CHK  = 3'd3,
`endif
      RUN  = 3'd4,
      ERR  = 3'd5
   } state_t;

   state_t     state, state_n;
   logic [7:0] n_words;
   logic [7:0] word_cnt;
   logic [7:0] low_byte;
   logic       wr_n;
   logic       last_word;
`ifdef BIP_LOADER_CHECKSUM_EN
   logic [7:0] csum;
`endif

   assign last_word = ((word_cnt + 8'd1) == n_words);
   assign o_State   = state;

   always_comb begin
      state_n = state;
      wr_n    = 1'b0;
      case (state)
         IDLE: begin
            if (i_RxValid) begin
               if ((i_RxData == 8'd0) || (int'(i_RxData) > CELDAS))
                  state_n = ERR;
               else
                  state_n = LOW;
            end
         end
         LOW: begin
            if (i_RxValid)
               state_n = HIGH;
         end
         HIGH: begin
            if (i_RxValid) begin
               wr_n = 1'b1;
               if (last_word)
`ifdef BIP_LOADER_CHECKSUM_EN
                  state_n = CHK;
`else
                  state_n = RUN;
`endif
               else
                  state_n = LOW;
            end
         end
`ifdef BIP_LOADER_CHECKSUM_EN
         CHK: begin
            if (i_RxValid)
               state_n = (i_RxData == csum) ? RUN : ERR;
         end
`endif
         RUN:     state_n = RUN;
         ERR:     state_n = ERR;
         default: state_n = ERR;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state      <= IDLE;
         n_words    <= 8'd0;
         word_cnt   <= 8'd0;
         low_byte   <= 8'd0;
         o_PmWr     <= 1'b0;
         o_PmWrAddr <= '0;
         o_PmWrData <= '0;
         o_CpuReset <= 1'b1;
         o_Done     <= 1'b0;
         o_Error    <= 1'b0;
`ifdef BIP_LOADER_CHECKSUM_EN
         csum       <= 8'd0;
`endif
      end else begin
         state      <= state_n;
         o_PmWr     <= wr_n;
         o_Done     <= (state == RUN);
         o_CpuReset <= (state != RUN);
         o_Error    <= (state == ERR);
         if ((state == IDLE) && i_RxValid)
            n_words <= i_RxData;
         if ((state == LOW) && i_RxValid)
            low_byte <= i_RxData;
         // Address/data only move on a write, so they hold between strobes.
         if (wr_n) begin
            o_PmWrData <= NBITS_D'({i_RxData, low_byte});
            o_PmWrAddr <= NBITS_O'(word_cnt);
            word_cnt   <= word_cnt + 8'd1;
         end
`ifdef BIP_LOADER_CHECKSUM_EN
         if (state == IDLE)
            csum <= 8'd0;
         else if (((state == LOW) || (state == HIGH)) && i_RxValid)
            csum <= csum ^ i_RxData;
`endif
      end
   end

endmodule
